// File: rtl/clk_tick_gen_pkg.sv
// Shared types and reset dividers for the programmable clock-enable generator.
// The reset dividers are the former fixed rtc and slow-peripheral divider constants.
package clk_tick_gen_pkg;

    typedef enum logic {TICK_PULSE = 1'b0, TICK_TOGGLE = 1'b1} tick_mode_t;

    localparam int tick_cnt_w = 16;

    localparam logic [tick_cnt_w-1:0] clk_divider_rtc  = 16'd49;
    localparam logic [tick_cnt_w-1:0] clk_divider_slow = 16'd9;

    // Channel 0 (rtc) sits in the LSBs.
    localparam logic [2*tick_cnt_w-1:0] DIV_INIT_DEFAULT = {clk_divider_slow, clk_divider_rtc};

endpackage

// File: rtl/tick_channel.sv
// One clock-enable channel: divider counter, shadow configuration, toggle level and tick.
// A divider write to a running channel waits in the shadow until the channel's terminal count.
module tick_channel
    import clk_tick_gen_pkg::*;
#(
    parameter int               CNT_W     = tick_cnt_w,
    parameter logic [CNT_W-1:0] DIV_INIT  = '0,
    parameter tick_mode_t       MODE_INIT = TICK_PULSE,
    parameter logic             EN_INIT   = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic             sync,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic             cfg_en,
    output logic             tick_o,
    output logic             lvl_o,
    output logic             pend_o
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_sh_div;
    tick_mode_t       r_mode;
    tick_mode_t       r_sh_mode;
    logic             r_en;
    logic             r_lvl;
    logic             r_tick;
    logic             r_pend;

    logic             w_tc;
    logic             w_direct;
    logic             w_restart;
    tick_mode_t       w_cfg_mode;
    tick_mode_t       w_next_mode;

    assign w_cfg_mode  = tick_mode_t'(cfg_mode);
    assign w_tc        = r_en && (r_cnt == r_div);
    // Writes bypass the shadow when the channel is idle, being disabled, or restarted by sync.
    assign w_direct    = we && (sync || !r_en || !cfg_en);
    assign w_restart   = r_en && sync;
    assign w_next_mode = r_pend ? r_sh_mode : r_mode;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_div     <= DIV_INIT;
            r_sh_div  <= DIV_INIT;
            r_mode    <= MODE_INIT;
            r_sh_mode <= MODE_INIT;
            r_en      <= EN_INIT;
            r_lvl     <= 1'b0;
            r_tick    <= 1'b0;
            r_pend    <= 1'b0;
        end else if (w_direct) begin
            r_div  <= cfg_div;
            r_mode <= w_cfg_mode;
            r_en   <= cfg_en;
            r_cnt  <= '0;
            r_lvl  <= 1'b0;
            r_tick <= 1'b0;
            r_pend <= 1'b0;
        end else if (w_restart) begin
            if (r_pend) begin
                r_div  <= r_sh_div;
                r_mode <= r_sh_mode;
            end
            r_cnt  <= '0;
            r_lvl  <= 1'b0;
            r_tick <= 1'b0;
            r_pend <= 1'b0;
        end else if (!r_en) begin
            r_cnt  <= '0;
            r_lvl  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            if (w_tc) begin
                r_cnt  <= '0;
                // The mode in force during the ending period decides this tick.
                r_tick <= (r_mode == TICK_PULSE) || !r_lvl;
                r_lvl  <= (r_mode == TICK_TOGGLE) && (w_next_mode == TICK_TOGGLE) && !r_lvl;
                if (r_pend) begin
                    r_div  <= r_sh_div;
                    r_mode <= r_sh_mode;
                end
                r_pend <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
            if (we) begin
                r_sh_div  <= cfg_div;
                r_sh_mode <= w_cfg_mode;
                r_pend    <= 1'b1;
            end
        end
    end

    assign tick_o = r_tick;
    assign lvl_o  = r_lvl;
    assign pend_o = r_pend;

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock-enable generator for the system clock domain.
// cfg_we is a single-cycle strobe, no ready: every asserted cycle is one write to channel cfg_sel.
module clk_tick_gen
    import clk_tick_gen_pkg::*;
#(
    parameter int                     NCH       = 2,
    parameter int                     CNT_W     = tick_cnt_w,
    parameter logic [NCH*CNT_W-1:0]   DIV_INIT  = DIV_INIT_DEFAULT,
    parameter logic [NCH-1:0]         MODE_INIT = 2'b01,
    parameter logic [NCH-1:0]         EN_INIT   = 2'b11,
    localparam int                    SEL_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic             cfg_en,
    input  logic             sync,
    output logic [NCH-1:0]   tick_o,
    output logic [NCH-1:0]   lvl_o,
    output logic [NCH-1:0]   pend_o
);

    logic [NCH-1:0] w_we;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // Selects at or above NCH match no channel and are dropped.
        assign w_we[i] = cfg_we && (cfg_sel == SEL_W'(i));

        tick_channel #(
            .CNT_W     (CNT_W),
            .DIV_INIT  (DIV_INIT[i*CNT_W +: CNT_W]),
            .MODE_INIT (tick_mode_t'(MODE_INIT[i])),
            .EN_INIT   (EN_INIT[i])
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .we       (w_we[i]),
            .sync     (sync),
            .cfg_div  (cfg_div),
            .cfg_mode (cfg_mode),
            .cfg_en   (cfg_en),
            .tick_o   (tick_o[i]),
            .lvl_o    (lvl_o[i]),
            .pend_o   (pend_o[i])
        );
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Scoreboard bench for clk_tick_gen with three channels so an out-of-range select exists.
`timescale 1ns/1ps
module tb_clk_tick_gen;

    localparam int NCH   = 3;
    localparam int CNT_W = 16;
    localparam int W     = 3 * NCH;
    localparam logic [NCH*CNT_W-1:0] B_DIV_INIT  = {16'd4, 16'd9, 16'd49};
    localparam logic [NCH-1:0]       B_MODE_INIT = 3'b001;
    localparam logic [NCH-1:0]       B_EN_INIT   = 3'b111;

    logic             clock = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_mode;
    logic             cfg_en;
    logic             sync;
    logic [NCH-1:0]   tick_o;
    logic [NCH-1:0]   lvl_o;
    logic [NCH-1:0]   pend_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_started = 0;
    logic [W-1:0] exp_q[$];

    clk_tick_gen #(
        .NCH       (NCH),
        .CNT_W     (CNT_W),
        .DIV_INIT  (B_DIV_INIT),
        .MODE_INIT (B_MODE_INIT),
        .EN_INIT   (B_EN_INIT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .cfg_en   (cfg_en),
        .sync     (sync),
        .tick_o   (tick_o),
        .lvl_o    (lvl_o),
        .pend_o   (pend_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Per channel: position within the current period, active divider/mode/enable,
    // the shadow waiting for the end of the period, and the visible outputs.
    int unsigned m_pos[NCH];
    int unsigned m_div[NCH];
    int unsigned m_sdiv[NCH];
    bit          m_tog[NCH];
    bit          m_stog[NCH];
    bit          m_en[NCH];
    bit          m_pend[NCH];
    bit          m_lvl[NCH];
    bit          m_tick[NCH];

    function automatic void model_reset();
        logic [NCH*CNT_W-1:0] dv;
        dv = B_DIV_INIT;
        for (int c = 0; c < NCH; c++) begin
            m_pos[c]  = 0;
            m_div[c]  = int'(dv[c*CNT_W +: CNT_W]);
            m_sdiv[c] = m_div[c];
            m_tog[c]  = B_MODE_INIT[c];
            m_stog[c] = m_tog[c];
            m_en[c]   = B_EN_INIT[c];
            m_pend[c] = 0;
            m_lvl[c]  = 0;
            m_tick[c] = 0;
        end
    endfunction

    function automatic void model_clear(int c);
        m_pos[c]  = 0;
        m_lvl[c]  = 0;
        m_tick[c] = 0;
        m_pend[c] = 0;
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NCH; c++) begin
            bit wr;
            bit period_end;
            wr = cfg_we && (int'(cfg_sel) == c);
            period_end = m_en[c] && (m_pos[c] == m_div[c]);
            if (wr && (sync || !m_en[c] || !cfg_en)) begin
                m_div[c] = int'(cfg_div);
                m_tog[c] = cfg_mode;
                m_en[c]  = cfg_en;
                model_clear(c);
            end else if (m_en[c] && sync) begin
                if (m_pend[c]) begin
                    m_div[c] = m_sdiv[c];
                    m_tog[c] = m_stog[c];
                end
                model_clear(c);
            end else if (!m_en[c]) begin
                model_clear(c);
            end else begin
                if (period_end) begin
                    bit was_tog;
                    was_tog = m_tog[c];
                    if (m_pend[c]) begin
                        m_div[c] = m_sdiv[c];
                        m_tog[c] = m_stog[c];
                    end
                    if (!was_tog) begin
                        m_tick[c] = 1;
                        m_lvl[c]  = 0;
                    end else begin
                        m_tick[c] = !m_lvl[c];
                        m_lvl[c]  = m_tog[c] ? !m_lvl[c] : 1'b0;
                    end
                    m_pos[c]  = 0;
                    m_pend[c] = 0;
                end else begin
                    m_pos[c]  = m_pos[c] + 1;
                    m_tick[c] = 0;
                end
                if (wr) begin
                    m_sdiv[c] = int'(cfg_div);
                    m_stog[c] = cfg_mode;
                    m_pend[c] = 1;
                end
            end
        end
    endfunction

    function automatic logic [W-1:0] model_outputs();
        logic [W-1:0] e;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            e[c]         = m_tick[c];
            e[NCH + c]   = m_lvl[c];
            e[2*NCH + c] = m_pend[c];
        end
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        cyc++;
        if (reset) model_reset();
        else model_step();
        exp_q.push_back(model_outputs());
        mon_started = 1;
        #1;
    endtask

    task automatic idle();
        cfg_we = 0;
        sync   = 0;
    endtask

    task automatic write_cfg(input int sel, input int div, input bit mode, input bit en);
        cfg_we   = 1;
        cfg_sel  = 2'(sel);
        cfg_div  = CNT_W'(div);
        cfg_mode = mode;
        cfg_en   = en;
        step();
        cfg_we = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clock);
            if (mon_started) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_empty cyc=%0d: got no expectation, required one", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({pend_o, lvl_o, tick_o} !== e) begin
                        n_errors++;
                        $display("FAIL sb_outputs cyc=%0d: got pend/lvl/tick=%b expected %b",
                                 cyc, {pend_o, lvl_o, tick_o}, e);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500us;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        reset = 1; cfg_we = 0; cfg_sel = 0; cfg_div = 0; cfg_mode = 0; cfg_en = 1; sync = 0;
        model_reset();
        repeat (3) step();
        chk("reset_outputs", 32'({pend_o, lvl_o, tick_o}), 32'd0);
        reset = 0;

        // Default dividers: ch0 toggle D=49, ch1 pulse D=9, ch2 pulse D=4.
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k == 9)   chk("ch1_first_tick_early", 32'(tick_o[1]), 32'd0);
            if (k == 10)  chk("ch1_first_tick", 32'(tick_o[1]), 32'd1);
            if (k == 50)  chk("ch0_first_rise", 32'({lvl_o[0], tick_o[0]}), 32'b11);
            if (k == 100) chk("ch0_fall", 32'({lvl_o[0], tick_o[0]}), 32'b00);
        end

        // Shadowed divider write mid-period on ch1.
        repeat (3) step();
        write_cfg(1, 3, 0, 1);
        chk("ch1_pend_set", 32'(pend_o[1]), 32'd1);
        repeat (5) step();
        chk("ch1_pend_hold", 32'(pend_o[1]), 32'd1);
        step();
        chk("ch1_pend_clear_tc", 32'({pend_o[1], tick_o[1]}), 32'b01);
        repeat (3) step();
        chk("ch1_new_period_early", 32'(tick_o[1]), 32'd0);
        step();
        chk("ch1_new_period_tick", 32'(tick_o[1]), 32'd1);

        // Pulse D=0 on ch2, then disable and re-enable.
        write_cfg(2, 0, 0, 1);
        repeat (8) step();
        chk("ch2_d0_tick_a", 32'(tick_o[2]), 32'd1);
        step();
        chk("ch2_d0_tick_b", 32'(tick_o[2]), 32'd1);
        write_cfg(2, 0, 0, 0);
        chk("ch2_disabled", 32'({pend_o[2], tick_o[2]}), 32'd0);
        step();
        write_cfg(2, 0, 0, 1);
        chk("ch2_reenable_edge", 32'(tick_o[2]), 32'd0);
        step();
        chk("ch2_resumed", 32'(tick_o[2]), 32'd1);

        // sync at an arbitrary phase.
        repeat ($urandom_range(3, 30)) step();
        sync = 1;
        step();
        sync = 0;
        chk("sync_clear", 32'({lvl_o, tick_o}), 32'd0);
        repeat (3) step();
        chk("sync_ch1_early", 32'(tick_o[1]), 32'd0);
        step();
        chk("sync_ch1_tick", 32'(tick_o[1]), 32'd1);

        // Write on the same cycle as ch1's terminal count, then overwrite before the next one.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_en[1] && m_pos[1] == m_div[1]) found = 1;
            else step();
        end
        chk("tc_search", 32'(found), 32'd1);
        write_cfg(1, 6, 1, 1);
        chk("tc_write_pend_tick", 32'({pend_o[1], tick_o[1]}), 32'b11);
        repeat (2) step();
        write_cfg(1, 5, 0, 1);
        chk("overwrite_pend", 32'(pend_o[1]), 32'd1);
        step();
        chk("overwrite_applied", 32'({pend_o[1], tick_o[1]}), 32'b01);
        write_cfg(3, 1, 1, 0);
        repeat (4) step();
        chk("overwrite_period_early", 32'({lvl_o[1], tick_o[1]}), 32'd0);
        step();
        chk("overwrite_period_tick", 32'({lvl_o[1], tick_o[1]}), 32'b01);
        chk("sel3_ignored_pend", 32'(pend_o), 32'd0);

        // Asynchronous reset mid-period with a pending write.
        write_cfg(0, 7, 1, 1);
        chk("pre_reset_pend", 32'(pend_o[0]), 32'd1);
        #2;
        reset = 1;
        exp_q.delete();
        model_reset();
        exp_q.push_back(model_outputs());
        #1;
        chk("async_reset_outputs", 32'({pend_o, lvl_o, tick_o}), 32'd0);
        step();
        reset = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (k == 10) chk("post_reset_ch1", 32'(tick_o[1]), 32'd1);
            if (k == 50) chk("post_reset_ch0", 32'({pend_o[0], lvl_o[0], tick_o[0]}), 32'b011);
        end

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_sel  = 2'($urandom_range(0, 3));
            cfg_div  = CNT_W'($urandom_range(0, 12));
            cfg_mode = 1'($urandom_range(0, 1));
            cfg_en   = ($urandom_range(0, 5) != 0);
            sync     = ($urandom_range(0, 40) == 0);
            step();
        end
        idle();
        step();
        @(negedge clock);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
